// File: rtl/oled_report.sv
// Converts the captured cycle count to decimal and writes it, plus a
// +/- line for the check flags, into the OLED character buffer.
module oled_report #(
   parameter logic [5:0] CNT_ADDR = 6'd32,
   parameter logic [5:0] CHK_ADDR = 6'd48
) (
   input  logic        sysclk,
   input  logic        cpu_resetn,
   input  logic        halt,
   input  logic [31:0] cycles,
   input  logic [3:0]  check,
   output logic        busy,
   output logic        done,
   output logic        we_o,
   output logic [5:0]  waddr_o,
   output logic [7:0]  wdata_o
);

   typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

   state_t      state, state_nxt;
   logic        halt_q;
   logic        trig;
   logic [31:0] bin;
   logic [39:0] bcd, bcd_adj;
   logic [3:0]  chk;
   logic [4:0]  step;
   logic [3:0]  idx;
   logic [9:0]  blank;
   logic [5:0]  nx_addr;
   logic [7:0]  nx_data;

   assign trig = halt & ~halt_q;

   always_ff @(posedge sysclk or negedge cpu_resetn)
      if (!cpu_resetn) state <= IDLE;
      else             state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (trig) state_nxt = CONV;
         CONV:       if (step == 5'd31) state_nxt = WRITE;
         WRITE:      if (idx == 4'd14) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Double-dabble correction applied before each shift.
   always_comb begin
      logic [3:0] nib;
      bcd_adj = bcd;
      for (int n = 0; n < 10; n++) begin
         nib = bcd[4*n +: 4];
         bcd_adj[4*n +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   end

   // Leading-zero blanking: a digit blanks while it and every higher digit are 0.
   always_comb begin
      logic z;
      z = 1'b1;
      blank = '0;
      for (int i = 0; i < 10; i++) begin
         z = z & (bcd[4*(9-i) +: 4] == 4'd0);
         blank[i] = z && (i < 9);
      end
   end

   always_comb begin
      int         di;
      logic [1:0] j;
      nx_addr = '0;
      nx_data = '0;
      di = 9 - int'(idx);
      j  = 2'(idx - 4'd10);
      if (idx < 4'd10) begin
         nx_addr = CNT_ADDR + {2'b00, idx};
         nx_data = blank[idx] ? 8'h20 : {4'h3, bcd[4*di +: 4]};
      end else begin
         nx_addr = CHK_ADDR + {4'b0000, j};
         nx_data = chk[2'd3 - j] ? 8'h2B : 8'h2D;
      end
   end

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         // Treat halt as already high so a halt held through reset is not a trigger.
         halt_q  <= 1'b1;
         bin     <= '0;
         bcd     <= '0;
         chk     <= '0;
         step    <= '0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         halt_q  <= halt;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
         case (state)
            IDLE, DONE: if (trig) begin
               bin  <= cycles;
               chk  <= check;
               bcd  <= '0;
               step <= '0;
               busy <= 1'b1;
               done <= 1'b0;
            end
            CONV: begin
               {bcd, bin} <= {bcd_adj[38:0], bin, 1'b0};
               step       <= step + 5'd1;
               idx        <= '0;
            end
            WRITE: begin
               if (idx == 4'd14) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end else begin
                  we_o    <= 1'b1;
                  waddr_o <= nx_addr;
                  wdata_o <= nx_data;
                  idx     <= idx + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_report.sv
// Directed bench for oled_report: logs every buffer write and compares
// report text, addresses and timing against hand-computed values.
module tb_oled_report;

   logic        sysclk = 1'b0;
   logic        cpu_resetn = 1'b0;
   logic        halt = 1'b0;
   logic [31:0] cycles = '0;
   logic [3:0]  check = '0;
   logic        busy, done, we_o, busy_b, done_b, we_b;
   logic [5:0]  waddr_o, waddr_b;
   logic [7:0]  wdata_o, wdata_b;

   oled_report dut (.sysclk(sysclk), .cpu_resetn(cpu_resetn), .halt(halt), .cycles(cycles),
      .check(check), .busy(busy), .done(done), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o));

   oled_report #(.CNT_ADDR(6'd60)) dut60 (.sysclk(sysclk), .cpu_resetn(cpu_resetn), .halt(halt),
      .cycles(cycles), .check(check), .busy(busy_b), .done(done_b), .we_o(we_b),
      .waddr_o(waddr_b), .wdata_o(wdata_b));

   always #5 sysclk = ~sysclk;

   typedef struct {int cyc; logic [5:0] a; logic [7:0] d;} wr_t;
   wr_t wq[$];
   wr_t wq60[$];
   int  cyc = 0;
   int  bad_idle = 0;
   int  nchk = 0;
   int  nerr = 0;

   always @(posedge sysclk) cyc <= cyc + 1;

   always @(negedge sysclk) begin
      if (we_o) wq.push_back('{cyc, waddr_o, wdata_o});
      else if (waddr_o != 6'd0 || wdata_o != 8'd0) bad_idle <= bad_idle + 1;
      if (we_b) wq60.push_back('{cyc, waddr_b, wdata_b});
   end

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Trigger sampled at the next rising edge, numbered k.
   task automatic fire(input logic [31:0] c, input logic [3:0] f, output int k);
      @(negedge sysclk);
      cycles = c;
      check  = f;
      halt   = 1'b1;
      k      = cyc + 1;
      @(negedge sysclk);
      halt   = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge sysclk);
         if (done) begin
            dc = cyc;
            break;
         end
      end
   endtask

   task automatic grab(input bit b60, input int s, output logic [79:0] cs, output logic [31:0] ks,
                       output logic [59:0] ca, output logic [23:0] ka, output int f, output int l);
      wr_t w;
      int  n;
      cs = '0; ks = '0; ca = '0; ka = '0; f = -1; l = -1;
      n = b60 ? wq60.size() : wq.size();
      for (int i = 0; i < 14; i++) begin
         if (n > s + i) begin
            w = b60 ? wq60[s+i] : wq[s+i];
            if (i < 10) begin
               cs = {cs[71:0], w.d};
               ca = {ca[53:0], w.a};
            end else begin
               ks = {ks[23:0], w.d};
               ka = {ka[17:0], w.a};
            end
            if (i == 0)  f = w.cyc;
            if (i == 13) l = w.cyc;
         end
      end
   endtask

   function automatic logic [59:0] seq_addr(input int base, input int n);
      logic [59:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r = {r[53:0], 6'(base + i)};
      return r;
   endfunction

   initial begin
      logic [79:0] cs;
      logic [31:0] ks;
      logic [59:0] ca;
      logic [23:0] ka;
      int k, s, s60, dc, f, l;

      #23;
      chk("reset_outputs", 80'({busy, done, we_o, waddr_o, wdata_o}), 80'd0);
      cpu_resetn = 1'b1;
      repeat (3) @(negedge sysclk);

      // 55 with all checks passing, including exact timing
      s = wq.size();
      fire(32'd55, 4'b1111, k);
      chk("busy_after_trig", 80'({busy, done}), 80'(2'b10));
      wait_done(dc);
      grab(1'b0, s, cs, ks, ca, ka, f, l);
      chk("t55_done_cyc", 80'(dc), 80'(k + 47));
      chk("t55_busy_at_done", 80'(busy), 80'd0);
      chk("t55_nwr", 80'(wq.size() - s), 80'd14);
      chk("t55_first_we", 80'(f), 80'(k + 33));
      chk("t55_last_we", 80'(l), 80'(k + 46));
      chk("t55_cnt_text", cs, 80'("        55"));
      chk("t55_cnt_addr", 80'(ca), 80'(seq_addr(32, 10)));
      chk("t55_chk_text", 80'(ks), 80'("++++"));
      chk("t55_chk_addr", 80'(ka), 80'(seq_addr(48, 4)));

      // zero: only the units digit is a numeral
      s = wq.size();
      fire(32'd0, 4'b0000, k);
      wait_done(dc);
      grab(1'b0, s, cs, ks, ca, ka, f, l);
      chk("t0_cnt_text", cs, 80'("         0"));
      chk("t0_chk_text", 80'(ks), 80'("----"));

      // all ones: every BCD digit in use, mixed check flags
      s = wq.size();
      fire(32'hFFFF_FFFF, 4'b0101, k);
      wait_done(dc);
      grab(1'b0, s, cs, ks, ca, ka, f, l);
      chk("tmax_cnt_text", cs, 80'("4294967295"));
      chk("tmax_chk_text", 80'(ks), 80'("-+-+"));
      chk("tmax_done_cyc", 80'(dc), 80'(k + 47));

      // halt held high, with a re-pulse during conversion and new inputs
      s = wq.size();
      @(negedge sysclk);
      cycles = 32'd777;
      check  = 4'b1000;
      halt   = 1'b1;
      repeat (9) @(negedge sysclk);
      halt   = 1'b0;
      cycles = 32'd999;
      check  = 4'b0111;
      @(negedge sysclk);
      halt = 1'b1;
      repeat (90) @(negedge sysclk);
      grab(1'b0, s, cs, ks, ca, ka, f, l);
      chk("held_nwr", 80'(wq.size() - s), 80'd14);
      chk("held_cnt_text", cs, 80'("       777"));
      chk("held_chk_text", 80'(ks), 80'("+---"));
      chk("held_done", 80'(done), 80'd1);
      halt = 1'b0;
      repeat (2) @(negedge sysclk);

      // new trigger on the edge of the last write is ignored
      s = wq.size();
      fire(32'd5, 4'b0011, k);
      while (cyc < k + 45) @(negedge sysclk);
      halt = 1'b1;
      repeat (40) @(negedge sysclk);
      grab(1'b0, s, cs, ks, ca, ka, f, l);
      chk("lastedge_nwr", 80'(wq.size() - s), 80'd14);
      chk("lastedge_text", cs, 80'("         5"));
      chk("lastedge_done", 80'(done), 80'd1);

      // reset in mid-write with halt high through release
      halt = 1'b0;
      repeat (2) @(negedge sysclk);
      s = wq.size();
      fire(32'd123456, 4'b1100, k);
      while (cyc < k + 39) @(negedge sysclk);
      halt = 1'b1;
      cpu_resetn = 1'b0;
      #1;
      chk("rst_mid_outputs", 80'({busy, done, we_o, waddr_o, wdata_o}), 80'd0);
      chk("rst_mid_nwr", 80'(wq.size() - s), 80'd7);
      @(negedge sysclk);
      cpu_resetn = 1'b1;
      repeat (60) @(negedge sysclk);
      chk("rst_no_writes", 80'(wq.size() - s), 80'd7);
      chk("rst_idle_flags", 80'({busy, done}), 80'd0);
      halt = 1'b0;
      @(negedge sysclk);
      s = wq.size();
      fire(32'd42, 4'b0001, k);
      wait_done(dc);
      grab(1'b0, s, cs, ks, ca, ka, f, l);
      chk("rst_new_nwr", 80'(wq.size() - s), 80'd14);
      chk("rst_new_text", cs, 80'("        42"));
      chk("rst_new_done_cyc", 80'(dc), 80'(k + 47));

      // address wrap on the instance based at 60
      s60 = wq60.size();
      fire(32'd1234, 4'b1010, k);
      wait_done(dc);
      grab(1'b1, s60, cs, ks, ca, ka, f, l);
      chk("wrap_nwr", 80'(wq60.size() - s60), 80'd14);
      chk("wrap_cnt_text", cs, 80'("      1234"));
      chk("wrap_cnt_addr", 80'(ca), 80'(seq_addr(60, 10)));
      chk("wrap_chk_text", 80'(ks), 80'("+-+-"));
      chk("wrap_done", 80'(done_b), 80'd1);

      chk("idle_bus_zero", 80'(bad_idle), 80'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
